// File: rtl/test_pattern_gen.sv
// Test pattern generator: colour bars, checkerboard, gradient and a cycling solid colour.
// Latency: rgb is registered, 1 clk after x/y/video_on; mode, frame count and offset update at frame end.
// Backpressure: none; the generator follows the timing inputs every clk.
module test_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CW         = 4,
    parameter int SPLIT_Y    = 412,
    parameter int CELL_SHIFT = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            p_tick,
    input  logic            video_on,
    input  logic [9:0]      x,
    input  logic [9:0]      y,
    input  logic [1:0]      mode_req,
    input  logic            mode_load,
    input  logic            scroll_en,
    output logic [3*CW-1:0] rgb,
    output logic [1:0]      mode_active,
    output logic [7:0]      frame_cnt
);

    localparam logic [9:0]  H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
    localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);
    localparam logic [10:0] SPLIT  = 11'(SPLIT_Y);
    localparam int          BAR_W  = H_ACTIVE / 7;

    // Gray level: alternating 1010... starting at the MSB.
    function automatic logic [CW-1:0] gray_level();
        logic [CW-1:0] g;
        for (int i = 0; i < CW; i++) begin
            g[i] = (((CW - 1 - i) % 2) == 0);
        end
        return g;
    endfunction

    localparam logic [CW-1:0] GRAY = gray_level();

    // Colour codes as {B,G,R} on/off flags.
    localparam logic [2:0] C_BLACK  = 3'b000;
    localparam logic [2:0] C_RED    = 3'b001;
    localparam logic [2:0] C_GREEN  = 3'b010;
    localparam logic [2:0] C_YELLOW = 3'b011;
    localparam logic [2:0] C_BLUE   = 3'b100;
    localparam logic [2:0] C_VIOLET = 3'b101;
    localparam logic [2:0] C_AQUA   = 3'b110;
    localparam logic [2:0] C_WHITE  = 3'b111;

    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_CHECK = 2'd1;
    localparam logic [1:0] MODE_GRAD  = 2'd2;

    logic [1:0]      pend_q,   pend_d;
    logic [1:0]      mode_q,   mode_d;
    logic [7:0]      fcnt_q,   fcnt_d;
    logic [9:0]      offset_q, offset_d;
    logic [3*CW-1:0] rgb_q,    rgb_d;

    logic            fe;
    logic [10:0]     sum;
    logic [9:0]      xs;
    logic [2:0]      bar;
    logic            in_area;
    logic            lower;
    logic            use_gray;
    logic [2:0]      colour;
    logic [CW-1:0]   grad;

    assign fe = p_tick && (x == H_LAST) && (y == V_LAST);

    // Frame-end bookkeeping: pending mode capture, mode switch, frame count, scroll offset.
    always_comb begin
        pend_d   = mode_load ? mode_req : pend_q;
        mode_d   = mode_q;
        fcnt_d   = fcnt_q;
        offset_d = offset_q;
        if (fe) begin
            // pend_d already holds a same-cycle mode_load, giving the bypass.
            mode_d = pend_d;
            fcnt_d = fcnt_q + 8'd1;
            if (scroll_en) begin
                offset_d = (offset_q == H_LAST) ? 10'd0 : offset_q + 10'd1;
            end
        end
    end

    // Scrolled x coordinate, wrapped into the active width.
    always_comb begin
        sum = {1'b0, x} + {1'b0, offset_q};
        xs  = (sum >= H_LIM) ? 10'(sum - H_LIM) : sum[9:0];
    end

    // Bar index by threshold compare; bar 6 absorbs the remainder of the line.
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 7; k++) begin
            if ({1'b0, xs} >= 11'(k * BAR_W)) begin
                bar = 3'(k);
            end
        end
    end

    // Pixel colour from the pre-update mode, offset and frame count.
    always_comb begin
        in_area  = video_on && ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
        lower    = ({1'b0, y} >= SPLIT);
        use_gray = 1'b0;
        colour   = C_BLACK;
        grad     = CW'(xs >> CELL_SHIFT);
        case (mode_q)
            MODE_BARS: begin
                if (!lower) begin
                    case (bar)
                        3'd0:    colour = C_WHITE;
                        3'd1:    colour = C_YELLOW;
                        3'd2:    colour = C_AQUA;
                        3'd3:    colour = C_GREEN;
                        3'd4:    colour = C_VIOLET;
                        3'd5:    colour = C_RED;
                        default: colour = C_BLUE;
                    endcase
                end else begin
                    case (bar)
                        3'd0:    colour = C_BLUE;
                        3'd1:    colour = C_BLACK;
                        3'd2:    colour = C_VIOLET;
                        3'd3:    use_gray = 1'b1;
                        3'd4:    colour = C_AQUA;
                        3'd5:    colour = C_BLACK;
                        default: colour = C_WHITE;
                    endcase
                end
            end
            MODE_CHECK: colour = (xs[CELL_SHIFT] ^ y[CELL_SHIFT]) ? C_WHITE : C_BLACK;
            MODE_GRAD:  colour = C_BLACK;
            default:    colour = fcnt_q[7:5];
        endcase

        if (!in_area) begin
            rgb_d = '0;
        end else if (mode_q == MODE_GRAD) begin
            rgb_d = {grad, grad, grad};
        end else if (use_gray) begin
            rgb_d = {GRAY, GRAY, GRAY};
        end else begin
            rgb_d = {{CW{colour[2]}}, {CW{colour[1]}}, {CW{colour[0]}}};
        end
    end

    // State registers; reset clears everything so a mid-frame release restarts in mode 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q   <= '0;
            mode_q   <= '0;
            fcnt_q   <= '0;
            offset_q <= '0;
            rgb_q    <= '0;
        end else begin
            pend_q   <= pend_d;
            mode_q   <= mode_d;
            fcnt_q   <= fcnt_d;
            offset_q <= offset_d;
            rgb_q    <= rgb_d;
        end
    end

    assign rgb         = rgb_q;
    assign mode_active = mode_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Self-checking bench for test_pattern_gen with default parameters.
// Behavioural model predicts rgb/mode_active/frame_cnt; a negedge process compares every cycle.
// Directed literal checks pin the model; a randomized phase follows.
module tb_test_pattern_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        p_tick = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [1:0]  mode_req = '0;
    logic        mode_load = 1'b0;
    logic        scroll_en = 1'b0;
    logic [11:0] rgb;
    logic [1:0]  mode_active;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model state
    logic [11:0] m_rgb = '0;
    int m_mode = 0;
    int m_pend = 0;
    int m_fcnt = 0;
    int m_off  = 0;

    localparam logic [11:0] UPPER [7] = '{12'hFFF, 12'h0FF, 12'hFF0, 12'h0F0, 12'hF0F, 12'h00F, 12'hF00};
    localparam logic [11:0] LOWER [7] = '{12'hF00, 12'h000, 12'hF0F, 12'hAAA, 12'hFF0, 12'h000, 12'hFFF};

    test_pattern_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .p_tick      (p_tick),
        .video_on    (video_on),
        .x           (x),
        .y           (y),
        .mode_req    (mode_req),
        .mode_load   (mode_load),
        .scroll_en   (scroll_en),
        .rgb         (rgb),
        .mode_active (mode_active),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_pixel(input int px, input int py, input logic vo,
                                              input int mode, input int off, input int fc);
        int xs;
        int bar;
        int g;
        int c;
        logic [3:0] gn;
        if (!vo || px >= 640 || py >= 480) return 12'h000;
        xs = (px + off) % 640;
        case (mode)
            0: begin
                bar = xs / 91;
                if (bar > 6) bar = 6;
                return (py < 412) ? UPPER[bar] : LOWER[bar];
            end
            1: return ((((xs / 32) % 2) ^ ((py / 32) % 2)) != 0) ? 12'hFFF : 12'h000;
            2: begin
                g  = (xs / 32) % 16;
                gn = 4'(g);
                return {gn, gn, gn};
            end
            default: begin
                c = fc / 32;
                return {(((c / 4) % 2) != 0) ? 4'hF : 4'h0,
                        (((c / 2) % 2) != 0) ? 4'hF : 4'h0,
                        ((c % 2) != 0) ? 4'hF : 4'h0};
            end
        endcase
    endfunction

    // Reference model: pixel from pre-update state, then frame-end updates.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rgb  <= '0;
            m_mode <= 0;
            m_pend <= 0;
            m_fcnt <= 0;
            m_off  <= 0;
        end else begin
            m_rgb  <= exp_pixel(int'(x), int'(y), video_on, m_mode, m_off, m_fcnt);
            m_pend <= mode_load ? int'(mode_req) : m_pend;
            if (p_tick && int'(x) == 639 && int'(y) == 479) begin
                m_mode <= mode_load ? int'(mode_req) : m_pend;
                m_fcnt <= (m_fcnt + 1) % 256;
                if (scroll_en) m_off <= (m_off + 1) % 640;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("rgb_vs_model", 32'(rgb), 32'(m_rgb));
            check("mode_vs_model", 32'(mode_active), 32'(m_mode));
            check("fcnt_vs_model", 32'(frame_cnt), 32'(m_fcnt));
        end
    end

    task automatic step(input int px, input int py, input logic vo, input logic pt, input logic ml);
        @(posedge clk);
        #2;
        x         = 10'(px);
        y         = 10'(py);
        video_on  = vo;
        p_tick    = pt;
        mode_load = ml;
    endtask

    // One frame-end pulse, optionally with a same-cycle mode load.
    task automatic fe(input logic ml);
        step(639, 479, 1'b1, 1'b1, ml);
        step(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pix_chk(input int px, input int py, input logic vo, input logic [11:0] exp, input string name);
        step(px, py, vo, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check(name, 32'(rgb), 32'(exp));
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input string name);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check({name, "_rgb"}, 32'(rgb), 32'h0);
        check({name, "_mode"}, 32'(mode_active), 32'h0);
        check({name, "_fcnt"}, 32'(frame_cnt), 32'h0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        check("reset_rgb", 32'(rgb), 32'h0);
        check("reset_mode", 32'(mode_active), 32'h0);
        check("reset_fcnt", 32'(frame_cnt), 32'h0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Mode 0 upper row
        pix_chk(0,   0, 1'b1, 12'hFFF, "bars_x0");
        pix_chk(90,  0, 1'b1, 12'hFFF, "bars_x90");
        pix_chk(91,  0, 1'b1, 12'h0FF, "bars_x91");
        pix_chk(545, 0, 1'b1, 12'h00F, "bars_x545");
        pix_chk(546, 0, 1'b1, 12'hF00, "bars_x546");
        pix_chk(639, 0, 1'b1, 12'hF00, "bars_x639");
        // Lower row and blanking
        pix_chk(100, 412, 1'b1, 12'h000, "low_x100");
        pix_chk(300, 412, 1'b1, 12'hAAA, "low_x300");
        pix_chk(600, 412, 1'b1, 12'hFFF, "low_x600");
        pix_chk(300, 412, 1'b0, 12'h000, "low_blank");
        pix_chk(700, 10,  1'b1, 12'h000, "x_out_of_range");

        // Mode load takes effect only at frame end
        mode_req = 2'd1;
        step(100, 100, 1'b1, 1'b0, 1'b1);
        step(100, 100, 1'b1, 1'b0, 1'b0);
        #1;
        check("mode_held_until_fe", 32'(mode_active), 32'd0);
        fe(1'b0);
        #1;
        check("mode_after_fe", 32'(mode_active), 32'd1);
        pix_chk(32, 0,  1'b1, 12'hFFF, "check_x32_y0");
        pix_chk(32, 32, 1'b1, 12'h000, "check_x32_y32");

        // Bypass: load in the frame-end cycle
        mode_req = 2'd0;
        fe(1'b1);
        #1;
        check("mode_bypass", 32'(mode_active), 32'd0);

        // Scrolling
        scroll_en = 1'b1;
        fe(1'b0);
        pix_chk(90, 0, 1'b1, 12'h0FF, "scroll1_x90");
        for (int i = 0; i < 639; i++) begin
            fe(1'b0);
            step($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b0, 1'b0);
        end
        pix_chk(90, 0, 1'b1, 12'hFFF, "scroll_wrap_x90");
        pix_chk(91, 0, 1'b1, 12'h0FF, "scroll_wrap_x91");
        scroll_en = 1'b0;

        // Mode 3 colour cycling and frame counter wrap
        do_reset("rst_a");
        mode_req = 2'd3;
        fe(1'b1);
        pix_chk(100, 100, 1'b1, 12'h000, "solid_frame1");
        for (int i = 0; i < 31; i++) begin
            fe(1'b0);
            step(200, 200, 1'b1, 1'b0, 1'b0);
        end
        #1;
        check("fcnt_32", 32'(frame_cnt), 32'd32);
        pix_chk(100, 100, 1'b1, 12'h00F, "solid_red");
        for (int i = 0; i < 223; i++) fe(1'b0);
        #1;
        check("fcnt_255", 32'(frame_cnt), 32'd255);
        fe(1'b0);
        #1;
        check("fcnt_wrap", 32'(frame_cnt), 32'd0);

        // Reset mid-frame from mode 2 with offset 17
        do_reset("rst_b");
        mode_req  = 2'd2;
        scroll_en = 1'b1;
        fe(1'b1);
        for (int i = 0; i < 16; i++) fe(1'b0);
        scroll_en = 1'b0;
        pix_chk(15, 0, 1'b1, 12'h111, "grad_off17");
        do_reset("rst_c");
        pix_chk(90,  0, 1'b1, 12'hFFF, "post_rst_x90");
        pix_chk(545, 0, 1'b1, 12'h00F, "post_rst_x545");

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            int r;
            int px;
            int py;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 5) == 0) mode_req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) scroll_en = ~scroll_en;
            if (r == 0) begin
                px = 639;
                py = 479;
            end else if (r == 1) begin
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 1023);
            end else begin
                px = $urandom_range(0, 639);
                py = $urandom_range(0, 479);
            end
            step(px, py, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0));
            if (i % 1000 == 500) begin
                #1 reset_n = 1'b0;
                #3 reset_n = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/test_pattern_gen.md
TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 Parameter CW, default 4, bits per colour channel.
REQ-004 Parameter SPLIT_Y, default 412, first line of the lower bar row.
REQ-005 Parameter CELL_SHIFT, default 5, log2 of checker cell size and gradient band width in pixels.
REQ-006 Ports: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  system clock, all state on rising edge.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 p_tick  in  1  pixel enable, one clk wide per pixel.
REQ-010 video_on  in  1  high inside the active area.
REQ-011 x, y  in  10 each  current pixel coordinate.
REQ-012 mode_req  in  2  requested pattern mode.
REQ-013 mode_load  in  1  strobe that captures mode_req.
REQ-014 scroll_en  in  1  enables horizontal scrolling.
REQ-015 rgb  out  3*CW  registered pixel, packed {B,G,R}, R in the least-significant bits.
REQ-016 mode_active  out  2  mode currently displayed.
REQ-017 frame_cnt  out  8  completed-frame counter.

Function
REQ-018 Frame-end event (FE) SHALL be p_tick && x==H_ACTIVE-1 && y==V_ACTIVE-1.
REQ-019 mode_load SHALL copy mode_req into a pending register, with the latest strobe winning.
REQ-020 On FE, mode_active SHALL take the pending value; a mode_load in the FE cycle SHALL be applied at that same FE (bypass).
REQ-021 On FE, frame_cnt SHALL increment modulo 256.
REQ-022 On FE with scroll_en=1, offset SHALL increment by 1 and wrap from H_ACTIVE-1 to 0.
REQ-023 On FE with scroll_en=0, offset SHALL hold its value.
REQ-024 Scrolled coordinate xs SHALL be x+offset, minus H_ACTIVE if the sum is >= H_ACTIVE.
REQ-025 Colour bars: bar width W SHALL be H_ACTIVE/7 (integer division); bar k occupies xs in [k*W,(k+1)*W) for k=0..5; bar 6 SHALL take the remainder up to H_ACTIVE-1.
REQ-026 Mode 0 upper row (y<SPLIT_Y), bars 0..6: white, yellow, aqua, green, violet, red, blue.
REQ-027 Mode 0 lower row (y>=SPLIT_Y), bars 0..6: blue, black, violet, gray, aqua, black, white.
REQ-028 Colour encoding: channel full = all ones, off = zero; yellow=R+G, aqua=G+B, violet=R+B.
REQ-029 Gray SHALL set every channel to the pattern 1010... MSB-first, truncated to CW bits (0xA for CW=4).
REQ-030 Mode 1: white if xs[CELL_SHIFT] XOR y[CELL_SHIFT] is 1, else black.
REQ-031 Mode 2: all three channels SHALL equal (xs>>CELL_SHIFT) mod 2^CW.
REQ-032 Mode 3: solid colour with index c=frame_cnt[7:5], where c bit0=R, bit1=G, bit2=B; each set bit drives its channel full, each clear bit drives it off.
REQ-033 Modes 0, 1 and 2 SHALL use xs; mode 3 SHALL ignore position.
REQ-034 rgb SHALL be black when video_on=0, or when x>=H_ACTIVE, or when y>=V_ACTIVE.
REQ-035 rgb SHALL be registered on every clk with latency exactly 1 clk from x/y/video_on, independent of p_tick.
REQ-036 Pixel computation SHALL use the offset, mode_active and frame_cnt values in effect before any FE update in the same cycle.

Reset
REQ-037 While reset_n=0: rgb=0, mode_active=0, pending mode=0, frame_cnt=0, offset=0, asynchronously.
REQ-038 Reset deasserted mid-frame SHALL resume in mode 0 with offset 0 and frame_cnt 0; no FE SHALL be inferred at deassertion.

Verification
REQ-039 Mode 0, offset 0, video_on=1, x=0/90/91/545/546/639 at y=0 -> rgb one clk later = FFF, FFF, 0FF, 00F, F00, F00.
REQ-040 Mode 0 lower row, y=412: x=100 -> 000, x=300 -> AAA, x=600 -> FFF; video_on=0 at x=300 -> 000.
REQ-041 mode_req=1 with mode_load mid-frame -> mode_active stays 0 until FE, then 1; at x=32,y=0 -> FFF; at x=32,y=32 -> 000.
REQ-042 scroll_en=1 for 640 FEs -> offset steps 0,1,...,639 then 0; in mode 0 with offset=1, x=90,y=0 -> 0FF.
REQ-043 Mode 3, run 32 FEs from reset -> rgb 000 during frames 0-31, then 00F (red) after frame_cnt reaches 32; frame_cnt wraps 255 -> 0.
REQ-044 Assert reset_n=0 mid-frame in mode 2 with offset 17 -> rgb=0, mode_active=0, offset=0 immediately; after release, mode 0 bars are correct on the next pixel.
